serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 100 ++++++++++
 tb/tb_serial_subtractor.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: request and operands in,
// registered difference, borrow and status out.
interface serial_subtractor_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] d;
    logic         b;
    logic         busy;
    logic         done;

    modport master (
        output start, x, y,
        input  d, b, busy, done
    );

    modport slave (
        input  start, x, y,
        output d, b, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor d = x - y, LSB first, one bit per clock,
// built around a single subtractor cell with a registered borrow.
module serial_subtractor #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_next;
    logic [N-1:0]  xs, ys, rs, d_r;
    logic          br, b_r, busy_r, done_r;
    logic [CW-1:0] cnt;
    logic          di, bo, last;

    function automatic logic diff_bit(input logic a, input logic s, input logic bi);
        return a ^ s ^ bi;
    endfunction

    function automatic logic borrow_bit(input logic a, input logic s, input logic bi);
        return (~a & s) | (~(a ^ s) & bi);
    endfunction

    always_comb begin
        di   = diff_bit(xs[0], ys[0], br);
        bo   = borrow_bit(xs[0], ys[0], br);
        last = (cnt == CW'(N - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Operand shift registers, borrow, bit counter and the held result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xs     <= '0;
            ys     <= '0;
            rs     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            d_r    <= '0;
            b_r    <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        xs     <= bus.x;
                        ys     <= bus.y;
                        rs     <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                RUN: begin
                    rs  <= {di, rs[N-1:1]};
                    xs  <= {1'b0, xs[N-1:1]};
                    ys  <= {1'b0, ys[N-1:1]};
                    br  <= bo;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        d_r    <= {di, rs[N-1:1]};
                        b_r    <= bo;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.d    = d_r;
    assign bus.b    = b_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: spec vectors, hand sequences,
// random operations at N=8 and an exhaustive back-to-back sweep at N=4.
module tb_serial_subtractor;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    int   cyc;

    logic [7:0] last_d;
    logic       last_b;

    serial_subtractor_if #(.N(8)) bus8 ();
    serial_subtractor_if #(.N(4)) bus4 ();

    serial_subtractor #(.N(8), .CW(3)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor #(.N(4), .CW(3)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] d;
        logic       b;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // One N=8 operation: checks latency, busy width, result hold, result and done width
    task automatic op8(input logic [7:0] xv, input logic [7:0] yv);
        int         lat;
        int         nbusy;
        logic       hold_ok;
        logic [7:0] ed;
        logic       eb;
        ed = xv - yv;
        eb = (xv < yv);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.x     = xv;
        bus8.y     = yv;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.x     = 8'($urandom);
        bus8.y     = 8'($urandom);
        lat     = 1;
        nbusy   = 0;
        hold_ok = 1'b1;
        while (!bus8.done && lat < 40) begin
            if (bus8.busy) nbusy++;
            if (bus8.d !== last_d || bus8.b !== last_b) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 9);
        check("busy_cycles", nbusy, 8);
        check("result_hold", hold_ok, 1);
        check("d", bus8.d, ed);
        check("b", bus8.b, eb);
        @(negedge clk);
        check("done_one_cycle", bus8.done, 0);
        last_d = ed;
        last_b = eb;
    endtask

    initial begin
        int guard;
        int ndone;
        int cur;
        int last_cyc;
        logic [3:0] ex, ey;

        n_pass  = 0;
        n_total = 0;
        last_d  = 8'h00;
        last_b  = 1'b0;

        tbl[0] = '{8'd200, 8'd55, 8'h91, 1'b0};
        tbl[1] = '{8'h05, 8'h0A, 8'hFB, 1'b1};
        tbl[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        tbl[4] = '{8'h30, 8'h10, 8'h20, 1'b0};
        tbl[5] = '{8'h80, 8'h7F, 8'h01, 1'b0};
        tbl[6] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        tbl[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

        // Reset held with start and all-ones operands
        rst = 1'b1;
        bus8.start = 1'b1; bus8.x = 8'hFF; bus8.y = 8'hFF;
        bus4.start = 1'b0; bus4.x = 4'h0;  bus4.y = 4'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_outputs", {bus8.d, bus8.b, bus8.busy, bus8.done}, 0);
        end
        rst = 1'b0;
        bus8.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", {bus8.d, bus8.b, bus8.busy, bus8.done}, 0);
        end

        // Table-driven spec vectors
        for (int i = 0; i < 8; i++) begin
            op8(tbl[i].x, tbl[i].y);
            check("tbl_d", bus8.d, tbl[i].d);
            check("tbl_b", bus8.b, tbl[i].b);
        end

        // start and operand changes during RUN are ignored
        @(negedge clk);
        bus8.start = 1'b1; bus8.x = 8'h30; bus8.y = 8'h10;
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus8.start = 1'b1; bus8.x = 8'h01; bus8.y = 8'h02;
        @(negedge clk);
        bus8.start = 1'b0;
        guard = 0;
        while (!bus8.done && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("ignored_start_done_seen", bus8.done, 1);
        check("ignored_start_d", bus8.d, 8'h20);
        check("ignored_start_b", bus8.b, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done) ndone++;
        end
        check("no_second_done", ndone, 0);
        last_d = 8'h20;
        last_b = 1'b0;
        op8(8'hC3, 8'h42);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        bus8.start = 1'b1; bus8.x = 8'h55; bus8.y = 8'h11;
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("midrun_busy_before_rst", bus8.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_d", bus8.d, 0);
        check("async_rst_flags", {bus8.b, bus8.busy, bus8.done}, 0);
        #1 rst = 1'b0;
        last_d = 8'h00;
        last_b = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_rst_idle", {bus8.busy, bus8.done, bus8.d}, 0);
        end
        op8(8'h80, 8'h7F);
        check("after_rst_d", bus8.d, 8'h01);

        // Random operations against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            op8(8'($urandom), 8'($urandom_range(255, 0)));
        end

        // Exhaustive N=4 sweep with start held high
        cur = 0;
        ndone = 0;
        last_cyc = 0;
        guard = 0;
        @(negedge clk);
        bus4.x = 4'h0; bus4.y = 4'h0; bus4.start = 1'b1;
        while (ndone < 256 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (bus4.done) begin
                ex = 4'(cur >> 4);
                ey = 4'(cur);
                check("n4_d", bus4.d, 4'(ex - ey));
                check("n4_b", bus4.b, (ex < ey) ? 1 : 0);
                if (ndone > 0) check("n4_spacing", cyc - last_cyc, 6);
                last_cyc = cyc;
                ndone++;
                cur++;
                if (cur < 256) begin
                    bus4.x = 4'(cur >> 4);
                    bus4.y = 4'(cur);
                end else begin
                    bus4.start = 1'b0;
                end
            end
        end
        bus4.start = 1'b0;
        check("n4_done_count", ndone, 256);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
